// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller and its AHB-Lite front-end.
package sdram_pkg;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB response codes
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Widest mask byte_mask can produce (hsize up to 7 = 128 bytes)
    localparam int unsigned MASK_W = 128;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        REQ,
        RD_WAIT,
        ERR1,
        ERR2
    } fe_state_t;

    // Byte mask: 1 = masked. Bytes in [aligned offset, +2^hsize) are enabled;
    // a misaligned offset is truncated down to the hsize boundary.
    function automatic logic [MASK_W-1:0] byte_mask(input logic [6:0] offset,
                                                    input logic [2:0] hsize);
        logic [6:0]        span_m1;
        logic [6:0]        aligned;
        logic [MASK_W-1:0] ones;
        span_m1 = 7'((8'd1 << hsize) - 8'd1);
        aligned = offset & ~span_m1;
        ones    = {MASK_W{1'b1}} >> (7'd127 - span_m1);
        return ~(ones << aligned);
    endfunction

endpackage

// File: rtl/sdram_ahb_frontend.sv
// AHB-Lite slave front-end: turns single AHB transfers into one outstanding
// req/rsp command for sdram_controller, stalling the bus with hreadyout.
module sdram_ahb_frontend
    import sdram_pkg::*;
#(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hsel,
    input  logic [AW-1:0]                 haddr,
    input  logic [1:0]                    htrans,
    input  logic                          hwrite,
    input  logic [2:0]                    hsize,
    input  logic [2:0]                    hburst,
    input  logic [3:0]                    hprot,
    input  logic                          hmasterlock,
    input  logic [DW-1:0]                 hwdata,
    input  logic                          hready,
    output logic                          hreadyout,
    output logic                          hresp,
    output logic [DW-1:0]                 hrdata,
    output logic                          req_valid,
    input  logic                          req_ready,
    output logic                          req_write,
    output logic [AW-$clog2(DW/8)-1:0]    req_addr,
    output logic [DW-1:0]                 req_wdata,
    output logic [DW/8-1:0]               req_mask,
    input  logic                          rsp_valid,
    input  logic [DW-1:0]                 rsp_rdata
);

    localparam int unsigned MW  = DW / 8;
    localparam int unsigned BB  = $clog2(MW);
    localparam int unsigned RAW = AW - BB;

    fe_state_t        state_q;
    fe_state_t        state_d;
    logic             accept;
    logic             size_err;
    logic             hreadyout_d;
    logic             hresp_d;
    logic [DW-1:0]    hrdata_d;
    logic             req_valid_d;
    logic             req_write_d;
    logic [RAW-1:0]   req_addr_d;
    logic [DW-1:0]    req_wdata_d;
    logic [MW-1:0]    req_mask_d;

    // Burst/protection/lock attributes carry no meaning for this slave
    logic unused_attr;
    assign unused_attr = ^{hburst, hprot, hmasterlock};

    // Address-phase qualification
    assign accept   = hsel & hready & (htrans inside {HTRANS_NONSEQ, HTRANS_SEQ});
    assign size_err = (hsize > 3'(BB));

    // Next state and next values of every registered output
    always_comb begin
        state_d     = state_q;
        hrdata_d    = hrdata;
        req_write_d = req_write;
        req_addr_d  = req_addr;
        req_wdata_d = req_wdata;
        req_mask_d  = req_mask;

        case (state_q)
            IDLE, ERR2: begin
                if (state_q == ERR2) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    if (size_err) begin
                        state_d = ERR1;
                    end else begin
                        state_d     = hwrite ? WDATA : REQ;
                        req_write_d = hwrite;
                        req_addr_d  = haddr[AW-1:BB];
                        req_mask_d  = hwrite ? MW'(byte_mask(7'(haddr[BB-1:0]), hsize)) : '0;
                    end
                end
            end
            WDATA: begin
                req_wdata_d = hwdata;
                state_d     = REQ;
            end
            REQ: begin
                if (req_ready) begin
                    state_d = req_write ? IDLE : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rsp_valid) begin
                    hrdata_d = rsp_rdata;
                    state_d  = IDLE;
                end
            end
            ERR1: begin
                state_d = ERR2;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        hreadyout_d = (state_d == IDLE) || (state_d == ERR2);
        hresp_d     = ((state_d == ERR1) || (state_d == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        req_valid_d = (state_d == REQ);
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
            hrdata    <= '0;
            req_valid <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_mask  <= '0;
        end else begin
            state_q   <= state_d;
            hreadyout <= hreadyout_d;
            hresp     <= hresp_d;
            hrdata    <= hrdata_d;
            req_valid <= req_valid_d;
            req_write <= req_write_d;
            req_addr  <= req_addr_d;
            req_wdata <= req_wdata_d;
            req_mask  <= req_mask_d;
        end
    end

endmodule

// File: tb/tb_sdram_ahb_frontend.sv
// Directed, table-driven bench for sdram_ahb_frontend (AW=16, DW=16).
module tb_sdram_ahb_frontend;
    import sdram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmasterlock;
    logic [15:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [15:0] hrdata;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [14:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_mask;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    // Single slave on the bus: bus-wide hready is this slave's hreadyout
    assign hready = hreadyout;

    sdram_ahb_frontend #(.AW(16), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hmasterlock(hmasterlock), .hwdata(hwdata), .hready(hready),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [2:0]  size;
        logic [15:0] data;      // hwdata for writes, rsp_rdata for reads
        logic [14:0] exp_addr;
        logic [1:0]  exp_mask;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    task automatic addr_phase(input logic [1:0] tr, input logic [15:0] a,
                              input logic wr, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = tr;
        haddr  = a;
        hwrite = wr;
        hsize  = sz;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 16'h0010, 3'd1, 16'hBEEF, 15'h0008, 2'b00, 1'b0};
        vecs[1] = '{1'b1, 16'h0013, 3'd0, 16'hAB00, 15'h0009, 2'b01, 1'b0};
        vecs[2] = '{1'b1, 16'h0012, 3'd0, 16'h00CD, 15'h0009, 2'b10, 1'b0};
        vecs[3] = '{1'b1, 16'h0021, 3'd1, 16'h5A5A, 15'h0010, 2'b00, 1'b0};
        vecs[4] = '{1'b0, 16'h0100, 3'd1, 16'h1234, 15'h0080, 2'b00, 1'b0};
        vecs[5] = '{1'b0, 16'h0003, 3'd0, 16'hCAFE, 15'h0001, 2'b00, 1'b0};
        vecs[6] = '{1'b1, 16'h0040, 3'd2, 16'h0000, 15'h0000, 2'b00, 1'b1};
        vecs[7] = '{1'b0, 16'h0050, 3'd3, 16'h0000, 15'h0000, 2'b00, 1'b1};
        vecs[8] = '{1'b1, 16'hFFFF, 3'd0, 16'h1200, 15'h7FFF, 2'b01, 1'b0};

        rst_n = 1'b0;
        bus_idle();
        haddr = '0; hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0; hprot = 4'd0;
        hmasterlock = 1'b0; hwdata = '0; req_ready = 1'b1;
        rsp_valid = 1'b0; rsp_rdata = '0;
        repeat (3) tick();

        // Reset values
        chk("rst hreadyout", 32'(hreadyout), 32'd1);
        chk("rst hresp",     32'(hresp),     32'd0);
        chk("rst hrdata",    32'(hrdata),    32'd0);
        chk("rst req_valid", 32'(req_valid), 32'd0);
        chk("rst req_write", 32'(req_write), 32'd0);
        chk("rst req_addr",  32'(req_addr),  32'd0);
        chk("rst req_wdata", 32'(req_wdata), 32'd0);
        chk("rst req_mask",  32'(req_mask),  32'd0);
        rst_n = 1'b1;
        tick();

        // Single transfers from the table, controller always ready
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("v%0d idle ready", i), 32'(hreadyout), 32'd1);
            addr_phase(HTRANS_NONSEQ, vecs[i].addr, vecs[i].wr, vecs[i].size);
            tick();
            bus_idle();
            if (vecs[i].exp_err) begin
                chk($sformatf("v%0d err1 rdy/resp/valid", i),
                    32'({hreadyout, hresp, req_valid}), 32'b010);
                tick();
                chk($sformatf("v%0d err2 rdy/resp/valid", i),
                    32'({hreadyout, hresp, req_valid}), 32'b110);
                tick();
                chk($sformatf("v%0d post-err resp", i), 32'({hreadyout, hresp}), 32'b10);
            end else if (vecs[i].wr) begin
                hwdata = vecs[i].data;
                chk($sformatf("v%0d wdata stall", i), 32'({hreadyout, req_valid}), 32'b00);
                tick();
                chk($sformatf("v%0d req_valid", i), 32'({hreadyout, req_valid}), 32'b01);
                chk($sformatf("v%0d req_addr", i),  32'(req_addr),  32'(vecs[i].exp_addr));
                chk($sformatf("v%0d req_mask", i),  32'(req_mask),  32'(vecs[i].exp_mask));
                chk($sformatf("v%0d req_wdata", i), 32'(req_wdata), 32'(vecs[i].data));
                chk($sformatf("v%0d req_write", i), 32'(req_write), 32'd1);
                tick();
                chk($sformatf("v%0d done", i), 32'({hreadyout, hresp, req_valid}), 32'b100);
            end else begin
                chk($sformatf("v%0d req_valid", i), 32'({hreadyout, req_valid}), 32'b01);
                chk($sformatf("v%0d req_addr", i),  32'(req_addr),  32'(vecs[i].exp_addr));
                chk($sformatf("v%0d req_mask", i),  32'(req_mask),  32'd0);
                chk($sformatf("v%0d req_write", i), 32'(req_write), 32'd0);
                tick();
                chk($sformatf("v%0d rd_wait", i), 32'({hreadyout, req_valid}), 32'b00);
                rsp_valid = 1'b1;
                rsp_rdata = vecs[i].data;
                tick();
                rsp_valid = 1'b0;
                chk($sformatf("v%0d rd done", i), 32'({hreadyout, hresp}), 32'b10);
                chk($sformatf("v%0d hrdata", i),  32'(hrdata), 32'(vecs[i].data));
            end
        end

        // Read with controller stalling 3 cycles; hrdata holds old value meanwhile
        req_ready = 1'b0;
        addr_phase(HTRANS_NONSEQ, 16'h0200, 1'b0, 3'd1);
        tick();
        bus_idle();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall c%0d valid", c), 32'({hreadyout, req_valid}), 32'b01);
            chk($sformatf("stall c%0d addr", c),  32'(req_addr), 32'h0100);
            chk($sformatf("stall c%0d write", c), 32'(req_write), 32'd0);
            if (c == 2) req_ready = 1'b1;
            tick();
        end
        req_ready = 1'b1;
        chk("stall rd_wait", 32'({hreadyout, req_valid}), 32'b00);
        chk("stall hrdata held", 32'(hrdata), 32'h0000CAFE);
        tick();
        rsp_valid = 1'b1;
        rsp_rdata = 16'h1234;
        tick();
        rsp_valid = 1'b0;
        chk("stall rd done", 32'(hreadyout), 32'd1);
        chk("stall hrdata",  32'(hrdata), 32'h1234);

        // INCR4 read burst at 0x0100, next beat held on the bus during each stall
        addr_phase(HTRANS_NONSEQ, 16'h0100, 1'b0, 3'd1);
        hburst = 3'b011;
        for (int b = 0; b < 4; b++) begin
            tick();
            if (b < 3) addr_phase(HTRANS_SEQ, 16'(16'h0100 + 16'(2 * (b + 1))), 1'b0, 3'd1);
            else bus_idle();
            chk($sformatf("burst b%0d valid", b), 32'({hreadyout, req_valid}), 32'b01);
            chk($sformatf("burst b%0d addr", b),  32'(req_addr), 32'(15'h0080 + 15'(b)));
            tick();
            chk($sformatf("burst b%0d rd_wait", b), 32'({hreadyout, req_valid}), 32'b00);
            rsp_valid = 1'b1;
            rsp_rdata = 16'(16'h1000 + 16'(b));
            tick();
            rsp_valid = 1'b0;
            chk($sformatf("burst b%0d ready", b),  32'(hreadyout), 32'd1);
            chk($sformatf("burst b%0d hrdata", b), 32'(hrdata), 32'(16'h1000 + 16'(b)));
        end
        hburst = 3'd0;
        tick();
        chk("burst quiet", 32'({hreadyout, req_valid}), 32'b10);

        // Reset while waiting for read data; late rsp must be ignored
        addr_phase(HTRANS_NONSEQ, 16'h0300, 1'b0, 3'd1);
        tick();
        bus_idle();
        chk("rstrd req_valid", 32'(req_valid), 32'd1);
        tick();
        chk("rstrd rd_wait", 32'({hreadyout, req_valid}), 32'b00);
        rst_n = 1'b0;
        tick();
        chk("rstrd after rst", 32'({hreadyout, hresp, req_valid}), 32'b100);
        chk("rstrd hrdata cleared", 32'(hrdata), 32'd0);
        rst_n = 1'b1;
        tick();
        rsp_valid = 1'b1;
        rsp_rdata = 16'h7777;
        tick();
        rsp_valid = 1'b0;
        chk("rstrd rsp ignored hrdata", 32'(hrdata), 32'd0);
        chk("rstrd rsp ignored state", 32'({hreadyout, hresp, req_valid}), 32'b100);
        tick();
        chk("rstrd still idle", 32'({hreadyout, req_valid}), 32'b10);

        // Idle traffic: BUSY transfers and unselected cycles
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                addr_phase(HTRANS_BUSY, 16'h0400, 1'b1, 3'd1);
            end else begin
                addr_phase(HTRANS_NONSEQ, 16'h0400, 1'b1, 3'd1);
                hsel = 1'b0;
            end
            tick();
            chk($sformatf("idle k%0d", k), 32'({hreadyout, hresp, req_valid}), 32'b100);
        end
        bus_idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
